cpu_ifetch_align: RTL

Instruction fetch/alignment stage of the mox125 pipeline, directly upstream of the decode stage. It pulls 32-bit words from instruction memory, buffers them as a halfword queue, and splits the stream into variable-length moxie instructions. Each instruction is a 16-bit opcode, optionally followed by a 32-bit operand. The stage presents one instruction per cycle with its PC, honours downstream stall, and redirects on flush.

---
 rtl/cpu_ifetch_pkg.sv | 38 +++
 rtl/cpu_ifetch_hwq.sv | 87 ++++++++
 rtl/cpu_ifetch_align.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cpu_ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ifetch_pkg
// Purpose  : Shared types, constants and the long-opcode decoder for the
//            mox125 instruction fetch/alignment stage.
// Contents : IFQ_DEPTH     - halfword queue capacity
//            HW_ENTRY_W    - packed width of one queue entry
//            hw_entry_t    - halfword data plus its byte address
//            is_long_op()  - 1 when the opcode's high byte takes a 32-bit
//                            operand
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ifetch_pkg;

   localparam int IFQ_DEPTH  = 8;
   localparam int HW_ENTRY_W = 48;

   typedef struct packed {
      logic [15:0] data;
      logic [31:0] addr;
   } hw_entry_t;

   // Opcodes whose high byte is in this set are followed by a 32-bit operand
   // (two further halfwords). Everything else, including all 1xxxxxxx
   // forms, is a single halfword.
   function automatic logic is_long_op(input logic [7:0] op_hi);
      case (op_hi)
         8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
         8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39:
            is_long_op = 1'b1;
         default:
            is_long_op = 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_ifetch_hwq.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ifetch_hwq
// Purpose  : 8-entry circular halfword queue. Accepts 0/1/2 pushes and 0/1/3
//            pops per cycle, exposes the three oldest entries and the fill
//            count, and can be cleared synchronously.
// Ports    : clk_i, rst_i      - clock, async active-high reset
//            clr_i             - synchronous clear (overrides push/pop)
//            push_n_i          - number of entries to push (0..2)
//            push0_i/push1_i   - entries to push, push0_i is the older one
//            pop_n_i           - number of entries to pop (0, 1 or 3)
//            head0_o..head2_o  - oldest three entries (valid up to count_o)
//            count_o           - current fill level 0..8
// Revision : 1.0 - initial release
// ============================================================================
module cpu_ifetch_hwq
   import cpu_ifetch_pkg::*;
(
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clr_i,
   input  logic [1:0]              push_n_i,
   input  logic [HW_ENTRY_W-1:0]   push0_i,
   input  logic [HW_ENTRY_W-1:0]   push1_i,
   input  logic [1:0]              pop_n_i,
   output logic [HW_ENTRY_W-1:0]   head0_o,
   output logic [HW_ENTRY_W-1:0]   head1_o,
   output logic [HW_ENTRY_W-1:0]   head2_o,
   output logic [3:0]              count_o
);

   hw_entry_t  mem_q [IFQ_DEPTH];
   logic [2:0] rd_ptr_q, rd_ptr_d;
   logic [2:0] wr_ptr_q, wr_ptr_d;
   logic [3:0] count_q,  count_d;
   logic [2:0] wr_ptr_p1;
   logic [2:0] rd_ptr_p1;
   logic [2:0] rd_ptr_p2;

   // Pointers are 3 bits wide so they wrap naturally around the 8 slots.
   assign wr_ptr_p1 = wr_ptr_q + 3'd1;
   assign rd_ptr_p1 = rd_ptr_q + 3'd1;
   assign rd_ptr_p2 = rd_ptr_q + 3'd2;

   always_comb begin
      rd_ptr_d = rd_ptr_q + {1'b0, pop_n_i};
      wr_ptr_d = wr_ptr_q + {1'b0, push_n_i};
      count_d  = count_q + {2'b00, push_n_i} - {2'b00, pop_n_i};
      if (clr_i) begin
         rd_ptr_d = 3'd0;
         wr_ptr_d = 3'd0;
         count_d  = 4'd0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q <= 3'd0;
         wr_ptr_q <= 3'd0;
         count_q  <= 4'd0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries beyond count_q are never consumed.
   always_ff @(posedge clk_i) begin
      if (!clr_i) begin
         if (push_n_i != 2'd0) begin
            mem_q[wr_ptr_q] <= push0_i;
         end
         if (push_n_i == 2'd2) begin
            mem_q[wr_ptr_p1] <= push1_i;
         end
      end
   end

   assign head0_o = mem_q[rd_ptr_q];
   assign head1_o = mem_q[rd_ptr_p1];
   assign head2_o = mem_q[rd_ptr_p2];
   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/cpu_ifetch_align.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ifetch_align
// Purpose  : mox125 instruction fetch/alignment stage. Fetches 32-bit
//            big-endian words, queues them as halfwords and emits one
//            variable-length instruction (16-bit opcode + optional 32-bit
//            operand) per cycle towards decode.
// Ports    : clk_i, rst_i          - clock, async active-high reset
//            imem_req_o/addr_o     - word fetch request and word address
//            imem_ack_i/data_i     - fetch accept and returned word
//            stall_i               - decode cannot take the current output
//            flush_i/branch_target_i - redirect to a new PC
//            opcode_o/operand_o/PC_o/valid_o - instruction to decode
// Revision : 1.0 - initial release
// ============================================================================
module cpu_ifetch_align
   import cpu_ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_1000,
   parameter int          QDEPTH       = 8
)(
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] branch_target_i,
   output logic [15:0] opcode_o,
   output logic [31:0] operand_o,
   output logic        valid_o,
   output logic [31:0] PC_o
);

   localparam logic [3:0] c_depth = 4'(QDEPTH);

   logic [31:0] fetch_addr_q, fetch_addr_d;
   logic        skip_q,       skip_d;
   logic        valid_q,      valid_d;
   logic [15:0] opcode_q,     opcode_d;
   logic [31:0] operand_q,    operand_d;
   logic [31:0] pc_q,         pc_d;

   logic [3:0]  q_count;
   logic [3:0]  free_slots;
   logic        accept;
   logic        load;
   logic        head_long;
   logic [1:0]  push_n;
   logic [1:0]  pop_n;
   hw_entry_t   push0, push1;
   hw_entry_t   head0, head1, head2;
   logic [HW_ENTRY_W-1:0] head0_raw, head1_raw, head2_raw;
   logic        unused_bits;

   cpu_ifetch_hwq u_hwq (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (flush_i),
      .push_n_i (push_n),
      .push0_i  (push0),
      .push1_i  (push1),
      .pop_n_i  (pop_n),
      .head0_o  (head0_raw),
      .head1_o  (head1_raw),
      .head2_o  (head2_raw),
      .count_o  (q_count)
   );

   assign head0 = head0_raw;
   assign head1 = head1_raw;
   assign head2 = head2_raw;

   // Requesting only with two free slots means an accepted word always fits,
   // even if nothing is popped in the same cycle. The request is masked
   // while reset is held so it reads 0 during reset.
   assign free_slots  = c_depth - q_count;
   assign imem_req_o  = ~rst_i & ~flush_i & (free_slots >= 4'd2);
   assign imem_addr_o = fetch_addr_q;
   assign accept      = imem_req_o & imem_ack_i;

   // Fetch address, skip flag and queue push.
   always_comb begin
      fetch_addr_d = fetch_addr_q;
      skip_d       = skip_q;
      push_n       = 2'd0;
      push0        = '0;
      push1        = '0;
      if (flush_i) begin
         fetch_addr_d = {branch_target_i[31:2], 2'b00};
         // A target in the second halfword of a word: the first halfword of
         // the next fetched word must be dropped.
         skip_d       = branch_target_i[1];
      end else if (accept) begin
         fetch_addr_d = fetch_addr_q + 32'd4;
         skip_d       = 1'b0;
         if (skip_q) begin
            push_n     = 2'd1;
            push0.data = imem_data_i[15:0];
            push0.addr = fetch_addr_q + 32'd2;
         end else begin
            push_n     = 2'd2;
            push0.data = imem_data_i[31:16];
            push0.addr = fetch_addr_q;
            push1.data = imem_data_i[15:0];
            push1.addr = fetch_addr_q + 32'd2;
         end
      end
   end

   // Output register and queue pop.
   assign load      = ~valid_q | ~stall_i;
   assign head_long = is_long_op(head0.data[15:8]);

   always_comb begin
      pop_n     = 2'd0;
      valid_d   = valid_q;
      opcode_d  = opcode_q;
      operand_d = operand_q;
      pc_d      = pc_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load) begin
         if (!head_long && (q_count >= 4'd1)) begin
            pop_n     = 2'd1;
            valid_d   = 1'b1;
            opcode_d  = head0.data;
            operand_d = 32'd0;
            pc_d      = head0.addr;
         end else if (head_long && (q_count >= 4'd3)) begin
            pop_n     = 2'd3;
            valid_d   = 1'b1;
            opcode_d  = head0.data;
            operand_d = {head1.data, head2.data};
            pc_d      = head0.addr;
         end else begin
            // Not enough halfwords yet: present a bubble, hold the rest.
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_addr_q <= RESET_VECTOR;
         skip_q       <= 1'b0;
         valid_q      <= 1'b0;
         opcode_q     <= 16'd0;
         operand_q    <= 32'd0;
         pc_q         <= RESET_VECTOR;
      end else begin
         fetch_addr_q <= fetch_addr_d;
         skip_q       <= skip_d;
         valid_q      <= valid_d;
         opcode_q     <= opcode_d;
         operand_q    <= operand_d;
         pc_q         <= pc_d;
      end
   end

   assign valid_o   = valid_q;
   assign opcode_o  = opcode_q;
   assign operand_o = operand_q;
   assign PC_o      = pc_q;

   // Operand halfwords' addresses and target bit 0 are intentionally ignored.
   assign unused_bits = ^{branch_target_i[0], head1.addr, head2.addr};

endmodule

`default_nettype wire
